// File: rtl/controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcodes,
// R-type function codes, ALU control codes and the internal control bundle.
package controller_pkg;

  // FSM state encoding; the numeric values are visible on the debug port.
  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12,
    S_ADDIWR  = 4'd13
  } state_t;

  // Opcodes, instr[31:26].
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;

  // R-type function codes, instr[5:0].
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes driven to the datapath.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_AND = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal ALU operation class handed from the FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Mux select encodings.
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMMSH   = 2'b11;

  // Raw (pre-reset-gating) control bundle produced by the state decoder.
  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic [1:0] alusrcb;
    logic [3:0] irwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // One-hot byte enable for the instruction register in each fetch state;
  // zero everywhere else so the IR is frozen from DECODE onward.
  function automatic logic [3:0] fetch_byte_en(input state_t s);
    logic [3:0] en;
    en = 4'b0000;
    case (s)
      S_FETCH1: en = 4'b0001;
      S_FETCH2: en = 4'b0010;
      S_FETCH3: en = 4'b0100;
      S_FETCH4: en = 4'b1000;
      default:  en = 4'b0000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/controller_aludec.sv
// ALU decoder: maps the FSM's ALU operation class (and funct for R-type)
// onto the 3-bit ALU control code.
module aludec
  import controller_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Pure combinational decode; unknown functs fall back to ADD.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/controller.sv
// Multicycle Moore controller for a byte-fetch MIPS-style datapath.
// Four fetch states assemble the instruction one byte at a time, DECODE
// dispatches on the opcode, and each instruction class finishes in its own
// short state chain before returning to FETCH1. All outputs depend only on
// the registered state (plus zero for pcen and funct for the ALU code), and
// all of them are forced low while reset is asserted.
module controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       memread,
  output logic       memwrite,
  output logic       alusrca,
  output logic       memtoreg,
  output logic       iord,
  output logic       regwrite,
  output logic       regdst,
  output logic       pcen,
  output logic [1:0] pcsrc,
  output logic [1:0] alusrcb,
  output logic [3:0] irwrite,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  ctrl_t      ctrl;
  logic [2:0] alucontrol_raw;

  // State register; reset drops straight to FETCH1 without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH1;
    else        state_q <= state_d;
  end

  // Next-state logic; unrecognised opcodes are dropped back to FETCH1.
  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1: state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_FETCH4;
      S_FETCH4: state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LB, OP_SB, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = S_RTYPEEX;
          OP_BEQ:                state_d = S_BEQEX;
          OP_J:                  state_d = S_JEX;
          default:               state_d = S_FETCH1;
        endcase
      end
      S_MEMADR: begin
        case (op)
          OP_LB:   state_d = S_LBRD;
          OP_SB:   state_d = S_SBWR;
          OP_ADDI: state_d = S_ADDIWR;
          default: state_d = S_FETCH1;
        endcase
      end
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      S_LBWR, S_SBWR, S_RTYPEWR, S_BEQEX, S_JEX, S_ADDIWR:
                 state_d = S_FETCH1;
      default:   state_d = S_FETCH1;
    endcase
  end

  // Moore output decode; everything not named in a state stays 0.
  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.pcwrite = 1'b1;
        ctrl.irwrite = fetch_byte_en(state_q);
        ctrl.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_LBRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
      end
      S_LBWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_SBWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_RTYPEEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_RTYPEWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_BEQEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.branch  = 1'b1;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.aluop   = ALUOP_SUB;
      end
      S_JEX: begin
        ctrl.pcwrite = 1'b1;
        ctrl.pcsrc   = PCSRC_JUMP;
      end
      S_ADDIWR: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b0;
      end
      default: ctrl = '0;
    endcase
  end

  aludec u_aludec (
    .aluop      (ctrl.aluop),
    .funct      (funct),
    .alucontrol (alucontrol_raw)
  );

  // Reset gating: the state register already sits at FETCH1 during reset,
  // but FETCH1 drives memread/pcwrite, so outputs are masked until release.
  assign memread    = reset & ctrl.memread;
  assign memwrite   = reset & ctrl.memwrite;
  assign alusrca    = reset & ctrl.alusrca;
  assign memtoreg   = reset & ctrl.memtoreg;
  assign iord       = reset & ctrl.iord;
  assign regwrite   = reset & ctrl.regwrite;
  assign regdst     = reset & ctrl.regdst;
  assign pcen       = reset & (ctrl.pcwrite | (ctrl.branch & zero));
  assign pcsrc      = reset ? ctrl.pcsrc   : 2'b00;
  assign alusrcb    = reset ? ctrl.alusrcb : 2'b00;
  assign irwrite    = reset ? ctrl.irwrite : 4'b0000;
  assign alucontrol = reset ? alucontrol_raw : ALU_ADD;
  assign state      = state_q;

endmodule

// File: tb/tb_controller.sv
// Bench for the multicycle controller. For every instruction the expected
// per-cycle output vector is pushed into exp_q when the opcode is driven,
// then popped and compared one cycle at a time, sampled 1ns after the edge.
module tb_controller;
  import controller_pkg::*;

  localparam int W = 23;

  logic       clk;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread, memwrite, alusrca, memtoreg, iord, regwrite, regdst, pcen;
  logic [1:0] pcsrc, alusrcb;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;
  logic [3:0] state;

  logic [W-1:0] dut_vec;
  logic [W-1:0] exp_q[$];
  int checks;
  int errors;

  controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .memread    (memread),
    .memwrite   (memwrite),
    .alusrca    (alusrca),
    .memtoreg   (memtoreg),
    .iord       (iord),
    .regwrite   (regwrite),
    .regdst     (regdst),
    .pcen       (pcen),
    .pcsrc      (pcsrc),
    .alusrcb    (alusrcb),
    .irwrite    (irwrite),
    .alucontrol (alucontrol),
    .state      (state)
  );

  // Observed outputs packed in the same field order as exp_vec.
  assign dut_vec = {state, memread, memwrite, alusrca, memtoreg, iord,
                    regwrite, regdst, pcen, pcsrc, alusrcb, irwrite, alucontrol};

  // Clock: 10ns period, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded time limit checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs for one state, written straight from the control table.
  function automatic logic [W-1:0] exp_vec(input int st, input logic [5:0] f, input logic z);
    logic [3:0] s;
    logic mr, mw, asa, mtr, io, rw, rd, pe;
    logic [1:0] ps, asb;
    logic [3:0] irw;
    logic [2:0] alu;
    s = 4'(st);
    {mr, mw, asa, mtr, io, rw, rd, pe} = 8'h00;
    ps = 2'b00; asb = 2'b00; irw = 4'b0000; alu = 3'b000;
    case (st)
      0, 1, 2, 3: begin
        mr = 1'b1; asb = 2'b01; pe = 1'b1;
        irw = 4'b0001 << st;
      end
      4:  asb = 2'b11;
      5:  begin asa = 1'b1; asb = 2'b10; end
      6:  begin mr = 1'b1; io = 1'b1; end
      7:  begin rw = 1'b1; mtr = 1'b1; end
      8:  begin mw = 1'b1; io = 1'b1; end
      9: begin
        asa = 1'b1;
        case (f)
          6'b100000: alu = 3'b000;
          6'b100010: alu = 3'b110;
          6'b100100: alu = 3'b001;
          6'b100101: alu = 3'b010;
          6'b101010: alu = 3'b111;
          default:   alu = 3'b000;
        endcase
      end
      10: begin rw = 1'b1; rd = 1'b1; end
      11: begin asa = 1'b1; ps = 2'b01; alu = 3'b110; pe = z; end
      12: begin pe = 1'b1; ps = 2'b10; end
      13: rw = 1'b1;
      default: ;
    endcase
    return {s, mr, mw, asa, mtr, io, rw, rd, pe, ps, asb, irw, alu};
  endfunction

  // Driver: apply an instruction and push its expected state trail.
  task automatic push_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
    int seq[$];
    op = o; funct = f; zero = z;
    seq = {0, 1, 2, 3, 4};
    case (o)
      6'b100000: begin seq.push_back(5); seq.push_back(6); seq.push_back(7); end
      6'b101000: begin seq.push_back(5); seq.push_back(8); end
      6'b001000: begin seq.push_back(5); seq.push_back(13); end
      6'b000000: begin seq.push_back(9); seq.push_back(10); end
      6'b000100: seq.push_back(11);
      6'b000010: seq.push_back(12);
      default: ;
    endcase
    foreach (seq[i]) exp_q.push_back(exp_vec(seq[i], f, z));
  endtask

  // Scoreboard consumer: compare n cycles, advancing one clock after each.
  task automatic drain(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (exp_q.size() == 0) begin
        check_eq($sformatf("%s_underflow%0d", name, i), dut_vec, {W{1'bx}});
        return;
      end
      check_eq($sformatf("%s_c%0d", name, i), dut_vec, exp_q.pop_front());
      @(posedge clk); #1;
    end
  endtask

  task automatic run_instr(input string name, input logic [5:0] o, input logic [5:0] f, input logic z);
    push_instr(o, f, z);
    drain(name, exp_q.size());
  endtask

  logic [5:0] funct_tbl[6];
  logic [5:0] junk_tbl[4];
  logic [5:0] op_tbl[6];

  initial begin
    checks = 0;
    errors = 0;
    funct_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111000};
    junk_tbl  = '{6'b111111, 6'b000001, 6'b100011, 6'b010101};
    op_tbl    = '{6'b000000, 6'b000010, 6'b000100, 6'b001000, 6'b100000, 6'b101000};

    // Reset held low: everything, including state, reads 0.
    reset = 1'b0; op = 6'b000000; funct = 6'b100010; zero = 1'b0;
    #1;
    check_eq("reset_t1", dut_vec, '0);
    @(posedge clk); #1;
    check_eq("reset_edge", dut_vec, '0);

    // Release mid-cycle: FETCH1 outputs appear at once, no edge needed.
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("release_fetch1", dut_vec, exp_vec(0, 6'b100010, 1'b0));
    @(posedge clk); #1;
    check_eq("release_fetch2", dut_vec, exp_vec(1, 6'b100010, 1'b0));
    // Finish FETCH2..DECODE, then let the ignored opcode fall back.
    @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
    check_eq("first_decode", dut_vec, exp_vec(4, 6'b100010, 1'b0));
    op = 6'b111111;
    @(posedge clk); #1;

    // Directed instructions.
    run_instr("rtype_sub", 6'b000000, 6'b100010, 1'b0);
    run_instr("beq_taken", 6'b000100, 6'b000000, 1'b1);
    run_instr("beq_not", 6'b000100, 6'b000000, 1'b0);
    run_instr("lb", 6'b100000, 6'b000000, 1'b0);
    run_instr("sb", 6'b101000, 6'b000000, 1'b1);
    run_instr("j", 6'b000010, 6'b000000, 1'b0);
    run_instr("addi", 6'b001000, 6'b000000, 1'b0);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0);
    for (int i = 0; i < 6; i++)
      run_instr($sformatf("rtype_f%0d", i), 6'b000000, funct_tbl[i], 1'b0);

    // Random instruction mix including junk opcodes.
    for (int n = 0; n < 30; n++) begin
      int k;
      logic [5:0] o;
      k = $urandom_range(0, 7);
      o = (k < 6) ? op_tbl[k] : junk_tbl[$urandom_range(0, 3)];
      run_instr($sformatf("rnd%0d", n), o, funct_tbl[$urandom_range(0, 5)],
                1'($urandom_range(0, 1)));
    end

    // Reset during RTYPEEX abandons the instruction before its write.
    push_instr(6'b000000, 6'b101010, 1'b0);
    drain("abort", 5);
    check_eq("abort_rtypeex", dut_vec, exp_q.pop_front());
    exp_q.delete();
    #2;
    reset = 1'b0;
    #1;
    check_eq("abort_async", dut_vec, '0);
    @(posedge clk); #1;
    check_eq("abort_held", dut_vec, '0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    run_instr("after_abort", 6'b000000, 6'b100100, 1'b0);
    check_eq("final_fetch1", dut_vec, exp_vec(0, 6'b100100, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
